// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage: control-bundle bit positions,
// bundle width and the hard-wired zero register index.
package id_ex_stage_pkg;

  localparam int CW = 10;

  localparam int CTRL_REG_WRITE = 0;
  localparam int CTRL_MEM_READ  = 1;
  localparam int CTRL_MEM_WRITE = 2;
  localparam int CTRL_ALU_SRC   = 3;
  localparam int CTRL_USES_RT   = 4;
  localparam int CTRL_ZERO_EXT  = 5;
  localparam int CTRL_ALU_OP_LO = 6;
  localparam int CTRL_ALU_OP_HI = 9;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/id_ex_stage_forward_unit.sv
// Per-source operand bypass: EX/MEM beats MEM/WB beats the held value.
// Register 0 never takes a bypass.
module forward_unit #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic [AW-1:0] src,
  input  logic [DW-1:0] held,
  input  logic          exmem_reg_write,
  input  logic [AW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_result,
  input  logic          memwb_reg_write,
  input  logic [AW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_data,
  output logic [DW-1:0] fwd
);
  import id_ex_stage_pkg::*;

  logic exmem_hit;
  logic memwb_hit;

  assign exmem_hit = exmem_reg_write && (exmem_rd != AW'(REG_ZERO)) && (exmem_rd == src);
  assign memwb_hit = memwb_reg_write && (memwb_rd != AW'(REG_ZERO)) && (memwb_rd == src);

  always_comb begin
    fwd = held;
    if (exmem_hit)      fwd = exmem_result;
    else if (memwb_hit) fwd = memwb_data;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and EX/MEM, MEM/WB
// operand forwarding on the execute-side outputs.
module id_ex_stage #(
  parameter int DW  = 32,
  parameter int AW  = 5,
  parameter int CW  = id_ex_stage_pkg::CW,
  parameter int SCW = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           id_valid,
  output logic           id_ready,
  input  logic [AW-1:0]  id_rs,
  input  logic [AW-1:0]  id_rt,
  input  logic [AW-1:0]  id_dest,
  input  logic [DW-1:0]  id_rs_data,
  input  logic [DW-1:0]  id_rt_data,
  input  logic [15:0]    id_imm,
  input  logic [CW-1:0]  id_ctrl,
  input  logic           flush,
  input  logic           ex_stall,
  input  logic           exmem_reg_write,
  input  logic [AW-1:0]  exmem_rd,
  input  logic [DW-1:0]  exmem_result,
  input  logic           memwb_reg_write,
  input  logic [AW-1:0]  memwb_rd,
  input  logic [DW-1:0]  memwb_data,
  output logic           ex_valid,
  output logic [CW-1:0]  ex_ctrl,
  output logic [AW-1:0]  ex_dest,
  output logic [DW-1:0]  ex_op_a,
  output logic [DW-1:0]  ex_op_b,
  output logic [DW-1:0]  ex_store_data,
  output logic [SCW-1:0] stall_cnt
);
  import id_ex_stage_pkg::*;

  logic           ex_valid_q,  ex_valid_d;
  logic [CW-1:0]  ex_ctrl_q,   ex_ctrl_d;
  logic [AW-1:0]  ex_dest_q,   ex_dest_d;
  logic [AW-1:0]  rs_idx_q,    rs_idx_d;
  logic [AW-1:0]  rt_idx_q,    rt_idx_d;
  logic [DW-1:0]  rs_val_q,    rs_val_d;
  logic [DW-1:0]  rt_val_q,    rt_val_d;
  logic [DW-1:0]  imm_q,       imm_d;
  logic [SCW-1:0] stall_cnt_q, stall_cnt_d;

  logic          load_use;
  logic          rs_dep;
  logic          rt_dep;
  logic          wb_retire;
  logic [DW-1:0] imm_ext;
  logic [DW-1:0] rs_fwd;
  logic [DW-1:0] rt_fwd;

  // A load in EX cannot bypass to the very next instruction, so it waits a cycle.
  assign rs_dep   = (ex_dest_q == id_rs);
  assign rt_dep   = id_ctrl[CTRL_USES_RT] && (ex_dest_q == id_rt);
  assign load_use = ex_valid_q && ex_ctrl_q[CTRL_MEM_READ] &&
                    (ex_dest_q != AW'(REG_ZERO)) && id_valid && (rs_dep || rt_dep);

  assign id_ready  = !ex_stall && !load_use && !flush;
  assign wb_retire = memwb_reg_write && (memwb_rd != AW'(REG_ZERO));
  assign imm_ext   = id_ctrl[CTRL_ZERO_EXT] ? {{(DW-16){1'b0}}, id_imm}
                                            : {{(DW-16){id_imm[15]}}, id_imm};

  always_comb begin
    ex_valid_d  = ex_valid_q;
    ex_ctrl_d   = ex_ctrl_q;
    ex_dest_d   = ex_dest_q;
    rs_idx_d    = rs_idx_q;
    rt_idx_d    = rt_idx_q;
    rs_val_d    = rs_val_q;
    rt_val_d    = rt_val_q;
    imm_d       = imm_q;
    stall_cnt_d = stall_cnt_q;
    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (ex_stall) begin
      // Write-back retires while we sit here; absorb it so it is not lost.
      if (wb_retire && (rs_idx_q == memwb_rd)) rs_val_d = memwb_data;
      if (wb_retire && (rt_idx_q == memwb_rd)) rt_val_d = memwb_data;
    end else if (load_use) begin
      ex_valid_d = 1'b0;
      ex_ctrl_d  = '0;
      if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
    end else if (id_valid) begin
      ex_valid_d = 1'b1;
      ex_ctrl_d  = id_ctrl;
      ex_dest_d  = id_dest;
      rs_idx_d   = id_rs;
      rt_idx_d   = id_rt;
      rs_val_d   = id_rs_data;
      rt_val_d   = id_rt_data;
      imm_d      = imm_ext;
    end else begin
      ex_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid_q  <= 1'b0;
      ex_ctrl_q   <= '0;
      ex_dest_q   <= '0;
      rs_idx_q    <= '0;
      rt_idx_q    <= '0;
      rs_val_q    <= '0;
      rt_val_q    <= '0;
      imm_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_ctrl_q   <= ex_ctrl_d;
      ex_dest_q   <= ex_dest_d;
      rs_idx_q    <= rs_idx_d;
      rt_idx_q    <= rt_idx_d;
      rs_val_q    <= rs_val_d;
      rt_val_q    <= rt_val_d;
      imm_q       <= imm_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  forward_unit #(.DW(DW), .AW(AW)) u_fwd_rs (
    .src             (rs_idx_q),
    .held            (rs_val_q),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_data      (memwb_data),
    .fwd             (rs_fwd)
  );

  forward_unit #(.DW(DW), .AW(AW)) u_fwd_rt (
    .src             (rt_idx_q),
    .held            (rt_val_q),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_data      (memwb_data),
    .fwd             (rt_fwd)
  );

  assign ex_valid      = ex_valid_q;
  assign ex_ctrl       = ex_ctrl_q;
  assign ex_dest       = ex_dest_q;
  assign ex_op_a       = rs_fwd;
  assign ex_op_b       = ex_ctrl_q[CTRL_ALU_SRC] ? imm_q : rt_fwd;
  assign ex_store_data = rt_fwd;
  assign stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: stimulus queues expected EX outputs, a
// negedge monitor pops one per valid EX cycle; control-path checks are inline.
module tb_id_ex_stage;
  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int CW  = 10;
  localparam int SCW = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           id_valid, id_ready;
  logic [AW-1:0]  id_rs, id_rt, id_dest;
  logic [DW-1:0]  id_rs_data, id_rt_data;
  logic [15:0]    id_imm;
  logic [CW-1:0]  id_ctrl;
  logic           flush, ex_stall;
  logic           exmem_reg_write, memwb_reg_write;
  logic [AW-1:0]  exmem_rd, memwb_rd;
  logic [DW-1:0]  exmem_result, memwb_data;
  logic           ex_valid;
  logic [CW-1:0]  ex_ctrl;
  logic [AW-1:0]  ex_dest;
  logic [DW-1:0]  ex_op_a, ex_op_b, ex_store_data;
  logic [SCW-1:0] stall_cnt;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] st;
    logic [CW-1:0] ctrl;
    logic [AW-1:0] dest;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  id_ex_stage #(.DW(DW), .AW(AW), .CW(CW), .SCW(SCW)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_rs(id_rs), .id_rt(id_rt), .id_dest(id_dest),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_ctrl(id_ctrl),
    .flush(flush), .ex_stall(ex_stall),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_dest(ex_dest),
    .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_store_data(ex_store_data),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, want, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [AW-1:0] rs, input logic [AW-1:0] rt, input logic [AW-1:0] dest,
                        input logic [DW-1:0] rsd, input logic [DW-1:0] rtd,
                        input logic [15:0] imm, input logic [CW-1:0] ctrl);
    id_valid = 1'b1; id_rs = rs; id_rt = rt; id_dest = dest;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_ctrl = ctrl;
  endtask

  task automatic clear_id();
    id_valid = 1'b0; id_rs = '0; id_rt = '0; id_dest = '0;
    id_rs_data = '0; id_rt_data = '0; id_imm = '0; id_ctrl = '0;
  endtask

  task automatic set_fwd(input logic we1, input logic [AW-1:0] rd1, input logic [DW-1:0] r1,
                         input logic we2, input logic [AW-1:0] rd2, input logic [DW-1:0] d2);
    exmem_reg_write = we1; exmem_rd = rd1; exmem_result = r1;
    memwb_reg_write = we2; memwb_rd = rd2; memwb_data = d2;
  endtask

  task automatic push(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] st,
                      input logic [CW-1:0] c, input logic [AW-1:0] d);
    exp_t e;
    e.a = a; e.b = b; e.st = st; e.ctrl = c; e.dest = d;
    q.push_back(e);
  endtask

  // Monitor: every valid EX cycle must match the next queued expectation.
  always @(negedge clk) begin
    if (rst === 1'b1 && ex_valid === 1'b1) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_valid: got ex_valid=1 want no output (t=%0t)", $time);
      end else begin
        mon_e = q.pop_front();
        chk("op_a",       ex_op_a,          mon_e.a);
        chk("op_b",       ex_op_b,          mon_e.b);
        chk("store_data", ex_store_data,    mon_e.st);
        chk("ex_ctrl",    DW'(ex_ctrl),     DW'(mon_e.ctrl));
        chk("ex_dest",    DW'(ex_dest),     DW'(mon_e.dest));
      end
    end
  end

  // ctrl encodings: 0x091 alu r-type (reg_write, uses_rt, alu_op=2),
  // 0x011 reg_write|uses_rt, 0x01C sw, 0x00B lw, 0x008 alu_src, 0x028 alu_src|zero_ext
  initial begin
    rst = 1'b0; flush = 1'b0; ex_stall = 1'b0;
    clear_id();
    set_fwd(1'b0, '0, '0, 1'b0, '0, '0);
    #2;
    chk("rst_ex_valid",  DW'(ex_valid),  '0);
    chk("rst_op_a",      ex_op_a,        '0);
    chk("rst_stall_cnt", DW'(stall_cnt), '0);
    chk("rst_id_ready",  DW'(id_ready),  32'd1);
    #10 rst = 1'b1;

    // basic capture
    cyc(); set_id(5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 16'h0, 10'h091);
    #1 chk("ready_basic", DW'(id_ready), 32'd1);
    cyc(); clear_id(); push(32'h11, 32'h22, 32'h22, 10'h091, 5'd3);

    // forwarding priority under stall, then write-back refresh of held rs
    cyc(); set_id(5'd5, 5'd6, 5'd7, 32'h55, 32'h66, 16'h0, 10'h011);
    cyc(); clear_id(); ex_stall = 1'b1;
    set_fwd(1'b1, 5'd5, 32'hAAAA, 1'b1, 5'd5, 32'hBBBB);
    push(32'hAAAA, 32'h66, 32'h66, 10'h011, 5'd7);
    #1 chk("ready_exstall", DW'(id_ready), '0);
    cyc(); set_fwd(1'b0, '0, '0, 1'b1, 5'd5, 32'hBBBB);
    push(32'hBBBB, 32'h66, 32'h66, 10'h011, 5'd7);
    cyc(); ex_stall = 1'b0; set_fwd(1'b0, '0, '0, 1'b0, '0, '0);
    push(32'hBBBB, 32'h66, 32'h66, 10'h011, 5'd7);

    // register 0 is never forwarded
    cyc(); set_id(5'd0, 5'd9, 5'd4, 32'h0, 32'h99, 16'h0, 10'h011);
    cyc(); clear_id(); set_fwd(1'b1, 5'd0, 32'h1234, 1'b1, 5'd0, 32'h5678);
    push(32'h0, 32'h99, 32'h99, 10'h011, 5'd4);

    // store: op_b is immediate, store data takes MEM/WB bypass on rt
    set_id(5'd10, 5'd11, 5'd0, 32'h100, 32'h200, 16'h0004, 10'h01C);
    cyc(); clear_id(); set_fwd(1'b0, '0, '0, 1'b1, 5'd11, 32'hCAFE);
    push(32'h100, 32'h4, 32'hCAFE, 10'h01C, 5'd0);

    // load-use: lw $8 in EX, dependent add waits one bubble
    set_id(5'd1, 5'd8, 5'd8, 32'h40, 32'h0, 16'h0010, 10'h00B);
    cyc(); set_fwd(1'b0, '0, '0, 1'b0, '0, '0);
    push(32'h40, 32'h10, 32'h0, 10'h00B, 5'd8);
    set_id(5'd8, 5'd9, 5'd12, 32'h777, 32'h9, 16'h0, 10'h011);
    #1 chk("ready_loaduse", DW'(id_ready), '0);
    cyc();
    chk("bubble_valid", DW'(ex_valid),  '0);
    chk("bubble_ctrl",  DW'(ex_ctrl),   '0);
    chk("bubble_cnt",   DW'(stall_cnt), 32'd1);
    chk("ready_after",  DW'(id_ready),  32'd1);
    cyc(); clear_id(); set_fwd(1'b0, '0, '0, 1'b1, 5'd8, 32'hDEAD);
    push(32'hDEAD, 32'h9, 32'h9, 10'h011, 5'd12);

    // flush replaces the load-use bubble; counter unchanged
    set_id(5'd1, 5'd8, 5'd8, 32'h40, 32'h0, 16'h0010, 10'h00B);
    cyc(); set_fwd(1'b0, '0, '0, 1'b0, '0, '0);
    push(32'h40, 32'h10, 32'h0, 10'h00B, 5'd8);
    set_id(5'd8, 5'd9, 5'd12, 32'h777, 32'h9, 16'h0, 10'h011); flush = 1'b1;
    #1 chk("ready_flush", DW'(id_ready), '0);
    cyc(); flush = 1'b0; clear_id();
    chk("flush_valid", DW'(ex_valid),  '0);
    chk("flush_cnt",   DW'(stall_cnt), 32'd1);

    // immediate extension
    set_id(5'd0, 5'd0, 5'd5, 32'h0, 32'h0, 16'hFFFF, 10'h008);
    cyc(); push(32'h0, 32'hFFFF_FFFF, 32'h0, 10'h008, 5'd5);
    set_id(5'd0, 5'd0, 5'd5, 32'h0, 32'h0, 16'hFFFF, 10'h028);
    cyc(); push(32'h0, 32'h0000_FFFF, 32'h0, 10'h028, 5'd5); clear_id();

    // eight more bubbles: 1 + 8 saturates a 3-bit counter at 7
    for (int i = 0; i < 8; i++) begin
      cyc(); set_id(5'd1, 5'd8, 5'd8, 32'h40, 32'h0, 16'h0010, 10'h00B);
      cyc(); push(32'h40, 32'h10, 32'h0, 10'h00B, 5'd8);
      set_id(5'd8, 5'd9, 5'd12, 32'h777, 32'h9, 16'h0, 10'h011);
    end
    cyc(); clear_id();
    chk("sat_cnt", DW'(stall_cnt), 32'd7);

    // asynchronous reset mid-operation
    set_id(5'd3, 5'd4, 5'd6, 32'h33, 32'h44, 16'h0, 10'h011);
    cyc(); clear_id(); push(32'h33, 32'h44, 32'h44, 10'h011, 5'd6);
    @(negedge clk); #2 rst = 1'b0;
    #1;
    chk("arst_ex_valid",  DW'(ex_valid),  '0);
    chk("arst_op_a",      ex_op_a,        '0);
    chk("arst_stall_cnt", DW'(stall_cnt), '0);
    cyc(); rst = 1'b1;
    cyc(); cyc();
    chk("queue_drained", DW'(q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
